// File: rtl/exc_mode_sequencer.sv
// exc_mode_sequencer
//   Exception entry/return sequencer for a banked multi-mode register file.
//   Owns the processor mode M, the I/F interrupt masks and one SPSR per
//   exception mode (abt, fiq, irq, und, svc). It arbitrates exception
//   requests and drives the register file write ports. An entry saves the
//   banked R14 and then loads the PC with the exception vector. A return
//   loads the PC from the banked LR and restores {I,F,M} from the SPSR.
//
//   Handshake: every request is a level signal that is sampled only in IDLE.
//   A request is accepted at the edge that leaves IDLE. Ack pulses for one
//   cycle in the last cycle of an entry or a return, and the requester
//   drops the request on Ack. A request still held when the sequencer is
//   back in IDLE is taken again. Mode_Wr never produces an Ack.
//
// Ports
//   Clk, Rst            clock (rising edge), synchronous active-high reset
//   Abt_Req .. Svc_Req  exception requests (level)
//   Ret_Req             exception return request (level)
//   Mode_Wr, CPSR_In    software write of {I,F,M[4:0]}
//   Cur_PC              current PC from the register file
//   LR_Data             register file read port C (banked R14)
//   M, I_Bit, F_Bit     current mode and interrupt masks
//   Write_Reg, Write_PC register file write enable / PC write select
//   W_Addr, W_Data      register file write address / data
//   PC_New              new PC value
//   R_Addr_C            read address C (14 during a return)
//   Busy, Ack           not-IDLE indicator / completion pulse
module exc_mode_sequencer #(
  parameter int              SIZE     = 32,
  parameter int              ADDR     = 4,
  parameter logic [SIZE-1:0] VEC_BASE = '0
) (
  input  logic            Clk,
  input  logic            Rst,
  input  logic            Abt_Req,
  input  logic            Fiq_Req,
  input  logic            Irq_Req,
  input  logic            Und_Req,
  input  logic            Svc_Req,
  input  logic            Ret_Req,
  input  logic            Mode_Wr,
  input  logic [6:0]      CPSR_In,
  input  logic [SIZE-1:0] Cur_PC,
  input  logic [SIZE-1:0] LR_Data,
  output logic [4:0]      M,
  output logic            I_Bit,
  output logic            F_Bit,
  output logic            Write_Reg,
  output logic            Write_PC,
  output logic [ADDR-1:0] W_Addr,
  output logic [SIZE-1:0] W_Data,
  output logic [SIZE-1:0] PC_New,
  output logic [ADDR-1:0] R_Addr_C,
  output logic            Busy,
  output logic            Ack
);

  typedef enum logic [1:0] {IDLE, SAVE_LR, LOAD_PC, RET} state_t;

  // Exception codes; each one also indexes the SPSR bank.
  localparam logic [2:0] EX_ABT = 3'd0;
  localparam logic [2:0] EX_FIQ = 3'd1;
  localparam logic [2:0] EX_IRQ = 3'd2;
  localparam logic [2:0] EX_UND = 3'd3;
  localparam logic [2:0] EX_SVC = 3'd4;

  localparam logic [4:0] MODE_USR = 5'b10000;
  localparam logic [4:0] MODE_FIQ = 5'b10001;
  localparam logic [4:0] MODE_IRQ = 5'b10010;
  localparam logic [4:0] MODE_SVC = 5'b10011;
  localparam logic [4:0] MODE_MON = 5'b10110;
  localparam logic [4:0] MODE_ABT = 5'b10111;
  localparam logic [4:0] MODE_HYP = 5'b11010;
  localparam logic [4:0] MODE_UND = 5'b11011;
  localparam logic [4:0] MODE_SYS = 5'b11111;

  state_t          state;
  logic [4:0]      m_q;
  logic            i_q;
  logic            f_q;
  logic [6:0]      spsr [0:4];
  logic [2:0]      code_q;
  logic [SIZE-1:0] pc_q;

  logic            take_entry;
  logic            take_ret;
  logic            take_mwr;
  logic [2:0]      win_code;
  logic [SIZE-1:0] lr_value;
  logic [SIZE-1:0] vec_addr;

  function automatic logic [4:0] mode_of(input logic [2:0] code);
    case (code)
      EX_ABT:  mode_of = MODE_ABT;
      EX_FIQ:  mode_of = MODE_FIQ;
      EX_IRQ:  mode_of = MODE_IRQ;
      EX_UND:  mode_of = MODE_UND;
      default: mode_of = MODE_SVC;
    endcase
  endfunction

  function automatic logic [2:0] code_of(input logic [4:0] mode);
    case (mode)
      MODE_ABT: code_of = EX_ABT;
      MODE_FIQ: code_of = EX_FIQ;
      MODE_IRQ: code_of = EX_IRQ;
      MODE_UND: code_of = EX_UND;
      default:  code_of = EX_SVC;
    endcase
  endfunction

  // Only the five modes that own an SPSR can return.
  function automatic logic is_exc_mode(input logic [4:0] mode);
    is_exc_mode = (mode == MODE_ABT) || (mode == MODE_FIQ) || (mode == MODE_IRQ) ||
                  (mode == MODE_UND) || (mode == MODE_SVC);
  endfunction

  function automatic logic is_legal_mode(input logic [4:0] mode);
    is_legal_mode = is_exc_mode(mode) || (mode == MODE_USR) || (mode == MODE_MON) ||
                    (mode == MODE_HYP) || (mode == MODE_SYS);
  endfunction

  function automatic logic [SIZE-1:0] vec_offset(input logic [2:0] code);
    case (code)
      EX_UND:  vec_offset = SIZE'(8'h04);
      EX_SVC:  vec_offset = SIZE'(8'h08);
      EX_ABT:  vec_offset = SIZE'(8'h10);
      EX_IRQ:  vec_offset = SIZE'(8'h18);
      default: vec_offset = SIZE'(8'h1C);
    endcase
  endfunction

  // IDLE arbitration. A masked FIQ/IRQ does not count as present, so it
  // neither wins nor blocks lower-priority requests. A Ret_Req blocks
  // Mode_Wr even when the current mode cannot return.
  always_comb begin
    take_entry = 1'b0;
    take_ret   = 1'b0;
    take_mwr   = 1'b0;
    win_code   = EX_SVC;
    if (Abt_Req) begin
      take_entry = 1'b1;
      win_code   = EX_ABT;
    end else if (Fiq_Req && !f_q) begin
      take_entry = 1'b1;
      win_code   = EX_FIQ;
    end else if (Irq_Req && !i_q) begin
      take_entry = 1'b1;
      win_code   = EX_IRQ;
    end else if (Und_Req) begin
      take_entry = 1'b1;
      win_code   = EX_UND;
    end else if (Svc_Req) begin
      take_entry = 1'b1;
      win_code   = EX_SVC;
    end else if (Ret_Req) begin
      take_ret = is_exc_mode(m_q);
    end else if (Mode_Wr) begin
      take_mwr = is_legal_mode(CPSR_In[4:0]);
    end
  end

  // abt/fiq/irq save PC+4; und/svc save the PC itself. Wraps mod 2^SIZE.
  assign lr_value = pc_q + (((code_q == EX_ABT) || (code_q == EX_FIQ) || (code_q == EX_IRQ))
                            ? SIZE'(4) : SIZE'(0));
  assign vec_addr = VEC_BASE + vec_offset(code_q);

  always_ff @(posedge Clk) begin
    if (Rst) begin
      state  <= IDLE;
      m_q    <= MODE_SVC;
      i_q    <= 1'b1;
      f_q    <= 1'b1;
      code_q <= EX_ABT;
      pc_q   <= '0;
      for (int n = 0; n < 5; n++) spsr[n] <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (take_entry) begin
            spsr[win_code] <= {i_q, f_q, m_q};
            m_q            <= mode_of(win_code);
            i_q            <= 1'b1;
            if (win_code == EX_FIQ) f_q <= 1'b1;
            code_q         <= win_code;
            pc_q           <= Cur_PC;
            state          <= SAVE_LR;
          end else if (take_ret) begin
            state <= RET;
          end else if (take_mwr) begin
            {i_q, f_q, m_q} <= CPSR_In;
          end
        end
        SAVE_LR: state <= LOAD_PC;
        LOAD_PC: state <= IDLE;
        RET: begin
          // The PC write this cycle used the exception bank; switch afterwards.
          {i_q, f_q, m_q} <= spsr[code_of(m_q)];
          state           <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign M     = m_q;
  assign I_Bit = i_q;
  assign F_Bit = f_q;

  always_comb begin
    Busy      = (state != IDLE);
    Write_Reg = 1'b0;
    Write_PC  = 1'b0;
    Ack       = 1'b0;
    W_Addr    = '0;
    W_Data    = '0;
    PC_New    = '0;
    R_Addr_C  = '0;
    case (state)
      SAVE_LR: begin
        Write_Reg = 1'b1;
        W_Addr    = ADDR'(14);
        W_Data    = lr_value;
      end
      LOAD_PC: begin
        Write_Reg = 1'b1;
        Write_PC  = 1'b1;
        Ack       = 1'b1;
        W_Addr    = ADDR'(15);
        W_Data    = vec_addr;
        PC_New    = vec_addr;
      end
      RET: begin
        R_Addr_C  = ADDR'(14);
        Write_Reg = 1'b1;
        Write_PC  = 1'b1;
        Ack       = 1'b1;
        W_Addr    = ADDR'(15);
        W_Data    = LR_Data;
        PC_New    = LR_Data;
      end
      default: ;
    endcase
  end

endmodule
